pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline stall/flush controller for the 5-stage RV32I core. It consumes the load-use stall request from the hazard detector, the EX-stage branch resolution, the data-memory handshake and the WB-stage halt request. From these it drives the write-enable, flush and bubble controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also enforces a data-memory timeout and keeps saturating stall, flush and cycle counters for performance debug.

## Interface
- `CNT_W`, default 32: width of each performance counter.
- `MEM_TIMEOUT`, default 16: maximum number of consecutive data-memory wait cycles before a fault is raised; must be ≥ 1.

Ports:
- `clk`  in  1  Core clock.
- `rst`  in  1  Synchronous reset, active-high.
- `stall_lu`  in  1  Load-use stall request from the hazard detector.
- `br_taken_ex`  in  1  Branch or jump resolved taken in EX.
- `dmem_req`  in  1  EX/MEM stage holds a load or store.
- `dmem_ready`  in  1  Data memory completes the access this cycle.
- `halt_req`  in  1  ECALL or EBREAK is in WB.
- `pc_we`  out  1  PC update enable.
- `ifid_we`  out  1  IF/ID write enable.
- `ifid_flush`  out  1  Load NOP into IF/ID.
- `idex_we`  out  1  ID/EX write enable.
- `idex_bubble`  out  1  Load bubble into ID/EX (all control bits 0).
- `exmem_we`  out  1  EX/MEM write enable.
- `memwb_bubble`  out  1  Load bubble into MEM/WB.
- `halted`  out  1  Core halted (sticky).
- `mem_err`  out  1  Memory timeout fault (sticky).
- `cnt_cycle`, `cnt_stall`, `cnt_flush`  out  `CNT_W` each  Performance counters.

## Operation
- FSM states: `RUN`, `MEM_WAIT`, `HALT`.
- Control outputs are combinational from state and inputs. State, wait counter, flags and counters are registered.
- While `rst`=1, all `*_we`=0 and `ifid_flush`=`idex_bubble`=`memwb_bubble`=1.
- In `RUN` or `MEM_WAIT`, conditions are evaluated in this strict priority order:
  1. `halt_req`: all `*_we`=0, `memwb_bubble`=1; next state `HALT`.
  2. `mw` = `dmem_req & ~dmem_ready`: all `*_we`=0, `memwb_bubble`=1, no flush; next state `MEM_WAIT`; `cnt_stall`++.
  3. `br_taken_ex`: all `*_we`=1, `ifid_flush`=1, `idex_bubble`=1; `cnt_flush`++. A simultaneous `stall_lu` is ignored, because the ID instruction is squashed.
  4. `stall_lu`: `pc_we`=`ifid_we`=0, `idex_bubble`=1, `exmem_we`=1; `cnt_stall`++.
  5. Otherwise: all `*_we`=1, with no flush and no bubble.
- Wait counter (`$clog2(MEM_TIMEOUT+1)` bits):
  - Cleared on every cycle with `mw`=0.
  - Incremented on every cycle with `mw`=1.
  - If `mw`=1 and the counter equals `MEM_TIMEOUT-1`: next state `HALT` and `mem_err`←1.
  - Result: at most `MEM_TIMEOUT` wait cycles before the fault.
- Exit from `MEM_WAIT`: the first cycle with `dmem_ready`=1 advances the pipeline normally (priority 3–5 apply). Next state `RUN`.
- `HALT`: all `*_we`=0, no flush or bubble, `halted`=1. Only `rst` exits this state.
- Counters:
  - `cnt_cycle` increments every cycle not in `HALT`.
  - All counters saturate at 2^`CNT_W`−1 and never wrap.

## Timing
- Reset values: state `RUN`, wait counter 0, `halted`=0, `mem_err`=0, all counters 0.
- Output latency is zero cycles: a control response appears in the same cycle as its input.
- `halted` and `mem_err` assert in the cycle after the triggering edge.
- Load-use response is exactly one bubble: after the bubble, ID/EX.MemRead=0, so the hazard detector drops `stall_lu`. The block does not register `stall_lu`.
- `br_taken_ex` is held stable by the frozen EX stage during `MEM_WAIT`, so no pending-flush storage is needed.
- Reset asserted mid-wait or in `HALT` returns to `RUN` at the next edge and clears both flags and all counters.

## Structure
- Shared package `pipe_pkg`: state enum `pipe_state_t`, default `CNT_W` and `MEM_TIMEOUT` constants.
- One sub-module, `sat_cnt` (parameter `W`; ports `clk`, `rst`, `inc`, `q`): a saturating counter, instantiated three times.

## Test plan
- Reset then idle: after `rst` is released, all `*_we`=1, no flush; 10 cycles later `cnt_cycle`=10.
- Load-use: `stall_lu`=1 for one cycle gives `pc_we`=`ifid_we`=0, `idex_bubble`=1, `exmem_we`=1; `cnt_stall`=1.
- Branch with simultaneous load-use: `br_taken_ex`=`stall_lu`=1 gives `pc_we`=1, `ifid_flush`=`idex_bubble`=1; `cnt_flush`=1 and `cnt_stall`=0.
- Memory wait: `dmem_req`=1 with `dmem_ready` low for 3 cycles, then high, gives a 3-cycle freeze with `memwb_bubble`=1; 4th cycle advances; `cnt_stall`=3; state returns to `RUN`.
- Timeout: `MEM_TIMEOUT`=4 and `dmem_ready` held 0 gives 4 frozen cycles, then `halted`=`mem_err`=1; `cnt_cycle` stops; `rst` clears both flags.
- Halt and saturation: `halt_req`=1 gives `memwb_bubble`=1 in that cycle, then `HALT`. With `CNT_W`=3 and 10 stalls, `cnt_stall`=7.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and default sizing for the pipeline stall/flush controller.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } pipe_state_t;

    localparam int CNT_W_DEF       = 32;
    localparam int MEM_TIMEOUT_DEF = 16;

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter used for the performance counters; holds at all-ones.
module sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the 5-stage core: drives pipeline register enables,
// flushes and bubbles, watches for data-memory timeouts and keeps perf counters.
//
// state    | meaning
// ---------|------------------------------------------------------------
// RUN      | pipeline advancing, load-use and branch hazards resolved
// MEM_WAIT | frozen on an outstanding data-memory access
// HALT     | ECALL/EBREAK retired or memory timeout; only reset leaves
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_lu,
    input  logic             br_taken_ex,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             halt_req,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_bubble,
    output logic             exmem_we,
    output logic             memwb_bubble,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] cnt_cycle,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_flush
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    pipe_state_t       state_q;
    pipe_state_t       state_d;
    logic [WAIT_W-1:0] wait_q;
    logic              halted_q;
    logic              mem_err_q;

    logic mw;
    logic active;
    logic timeout;
    logic inc_cycle;
    logic inc_stall;
    logic inc_flush;

    assign mw     = dmem_req & ~dmem_ready;
    assign active = (state_q != HALT);

    // A halt request outranks the memory wait, so it also masks the timeout.
    assign timeout = active & ~halt_req & mw & (wait_q == WAIT_LAST);

    assign inc_cycle = active;
    assign inc_stall = active & ~halt_req & (mw | (~br_taken_ex & stall_lu));
    assign inc_flush = active & ~halt_req & ~mw & br_taken_ex;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN, MEM_WAIT: begin
                if (halt_req) begin
                    state_d = HALT;
                end else if (mw) begin
                    state_d = timeout ? HALT : MEM_WAIT;
                end else begin
                    state_d = RUN;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        ifid_flush   = 1'b0;
        idex_we      = 1'b0;
        idex_bubble  = 1'b0;
        exmem_we     = 1'b0;
        memwb_bubble = 1'b0;
        if (rst) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            memwb_bubble = 1'b1;
        end else if (active) begin
            if (halt_req || mw) begin
                memwb_bubble = 1'b1;
            end else if (br_taken_ex) begin
                // The ID instruction is squashed, so a coincident load-use is moot.
                pc_we       = 1'b1;
                ifid_we     = 1'b1;
                idex_we     = 1'b1;
                exmem_we    = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (stall_lu) begin
                idex_we     = 1'b1;
                idex_bubble = 1'b1;
                exmem_we    = 1'b1;
            end else begin
                pc_we    = 1'b1;
                ifid_we  = 1'b1;
                idex_we  = 1'b1;
                exmem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= '0;
        end else if (active && mw) begin
            wait_q <= wait_q + WAIT_W'(1);
        end else begin
            wait_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q  <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            if (state_d == HALT) begin
                halted_q <= 1'b1;
            end
            if (timeout) begin
                mem_err_q <= 1'b1;
            end
        end
    end

    assign halted  = halted_q;
    assign mem_err = mem_err_q;

    sat_cnt #(.W(CNT_W)) u_cnt_cycle (
        .clk (clk),
        .rst (rst),
        .inc (inc_cycle),
        .q   (cnt_cycle)
    );

    sat_cnt #(.W(CNT_W)) u_cnt_stall (
        .clk (clk),
        .rst (rst),
        .inc (inc_stall),
        .q   (cnt_stall)
    );

    sat_cnt #(.W(CNT_W)) u_cnt_flush (
        .clk (clk),
        .rst (rst),
        .inc (inc_flush),
        .q   (cnt_flush)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a 32-bit/short-timeout instance plus a 3-bit
// counter instance driven from the same inputs for the saturation case.
module tb_pipe_ctrl;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall_lu = 1'b0, br_taken_ex = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0, halt_req = 1'b0;

    logic pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_bubble, halted, mem_err;
    logic [31:0] cnt_cycle, cnt_stall, cnt_flush;

    logic s_pc_we, s_ifid_we, s_ifid_flush, s_idex_we, s_idex_bubble, s_exmem_we, s_memwb_bubble;
    logic s_halted, s_mem_err;
    logic [2:0] s_cnt_cycle, s_cnt_stall, s_cnt_flush;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .stall_lu(stall_lu), .br_taken_ex(br_taken_ex),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt_req(halt_req),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we),
        .idex_bubble(idex_bubble), .exmem_we(exmem_we), .memwb_bubble(memwb_bubble),
        .halted(halted), .mem_err(mem_err),
        .cnt_cycle(cnt_cycle), .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
    );

    pipe_ctrl #(.CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .stall_lu(stall_lu), .br_taken_ex(br_taken_ex),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt_req(halt_req),
        .pc_we(s_pc_we), .ifid_we(s_ifid_we), .ifid_flush(s_ifid_flush), .idex_we(s_idex_we),
        .idex_bubble(s_idex_bubble), .exmem_we(s_exmem_we), .memwb_bubble(s_memwb_bubble),
        .halted(s_halted), .mem_err(s_mem_err),
        .cnt_cycle(s_cnt_cycle), .cnt_stall(s_cnt_stall), .cnt_flush(s_cnt_flush)
    );

    // Control vector packed as {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_bubble}.
    function automatic logic [6:0] ctl();
        return {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_bubble};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        stall_lu = 1'b0; br_taken_ex = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0; halt_req = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        vecs++;
        if (ctl() !== 7'b0010101) begin
            $display("FAIL reset_ctl got=%b exp=%b", ctl(), 7'b0010101); errs++;
        end
        vecs++;
        if ({halted, mem_err} !== 2'b00 || cnt_cycle !== 32'd0 || cnt_stall !== 32'd0 || cnt_flush !== 32'd0) begin
            $display("FAIL reset_state got halted=%b mem_err=%b cyc=%0d stall=%0d flush=%0d exp 0", halted, mem_err, cnt_cycle, cnt_stall, cnt_flush);
            errs++;
        end
        rst = 1'b0;
        #1;
        vecs++;
        if (ctl() !== 7'b1101010) begin
            $display("FAIL idle_ctl got=%b exp=%b", ctl(), 7'b1101010); errs++;
        end
        for (int i = 0; i < 10; i++) cyc();
        vecs++;
        if (cnt_cycle !== 32'd10) begin
            $display("FAIL idle_cnt_cycle got=%0d exp=10", cnt_cycle); errs++;
        end
    endtask

    task automatic test_load_use();
        do_reset();
        stall_lu = 1'b1;
        #1;
        vecs++;
        if (ctl() !== 7'b0001110) begin
            $display("FAIL load_use_ctl got=%b exp=%b", ctl(), 7'b0001110); errs++;
        end
        cyc();
        stall_lu = 1'b0;
        #1;
        vecs++;
        if (cnt_stall !== 32'd1 || cnt_flush !== 32'd0) begin
            $display("FAIL load_use_cnt got stall=%0d flush=%0d exp 1/0", cnt_stall, cnt_flush); errs++;
        end
        vecs++;
        if (ctl() !== 7'b1101010) begin
            $display("FAIL load_use_resume got=%b exp=%b", ctl(), 7'b1101010); errs++;
        end
    endtask

    task automatic test_branch();
        do_reset();
        br_taken_ex = 1'b1;
        stall_lu = 1'b1;
        #1;
        vecs++;
        if (ctl() !== 7'b1111110) begin
            $display("FAIL branch_ctl got=%b exp=%b", ctl(), 7'b1111110); errs++;
        end
        cyc();
        br_taken_ex = 1'b0;
        stall_lu = 1'b0;
        vecs++;
        if (cnt_flush !== 32'd1 || cnt_stall !== 32'd0) begin
            $display("FAIL branch_cnt got flush=%0d stall=%0d exp 1/0", cnt_flush, cnt_stall); errs++;
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        dmem_req = 1'b1;
        dmem_ready = 1'b0;
        br_taken_ex = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vecs++;
            if (ctl() !== 7'b0000001) begin
                $display("FAIL mem_wait_freeze[%0d] got=%b exp=%b", i, ctl(), 7'b0000001); errs++;
            end
            cyc();
        end
        dmem_ready = 1'b1;
        #1;
        vecs++;
        if (dut.state_q !== MEM_WAIT) begin
            $display("FAIL mem_wait_state got=%0d exp=%0d", dut.state_q, MEM_WAIT); errs++;
        end
        vecs++;
        if (ctl() !== 7'b1111110) begin
            $display("FAIL mem_wait_exit got=%b exp=%b", ctl(), 7'b1111110); errs++;
        end
        cyc();
        dmem_req = 1'b0;
        dmem_ready = 1'b0;
        br_taken_ex = 1'b0;
        vecs++;
        if (cnt_stall !== 32'd3 || cnt_flush !== 32'd1) begin
            $display("FAIL mem_wait_cnt got stall=%0d flush=%0d exp 3/1", cnt_stall, cnt_flush); errs++;
        end
        vecs++;
        if (dut.state_q !== RUN || halted !== 1'b0) begin
            $display("FAIL mem_wait_return got state=%0d halted=%b exp RUN/0", dut.state_q, halted); errs++;
        end
    endtask

    task automatic test_timeout();
        do_reset();
        dmem_req = 1'b1;
        dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            vecs++;
            if (ctl() !== 7'b0000001 || halted !== 1'b0 || mem_err !== 1'b0) begin
                $display("FAIL timeout_wait[%0d] got ctl=%b halted=%b mem_err=%b exp 0000001/0/0", i, ctl(), halted, mem_err);
                errs++;
            end
            cyc();
        end
        vecs++;
        if (halted !== 1'b1 || mem_err !== 1'b1) begin
            $display("FAIL timeout_flags got halted=%b mem_err=%b exp 1/1", halted, mem_err); errs++;
        end
        vecs++;
        if (ctl() !== 7'b0000000) begin
            $display("FAIL timeout_halt_ctl got=%b exp=%b", ctl(), 7'b0000000); errs++;
        end
        for (int i = 0; i < 3; i++) cyc();
        vecs++;
        if (cnt_cycle !== 32'd4 || cnt_stall !== 32'd4) begin
            $display("FAIL timeout_cnt got cyc=%0d stall=%0d exp 4/4", cnt_cycle, cnt_stall); errs++;
        end
        dmem_req = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        vecs++;
        if (halted !== 1'b0 || mem_err !== 1'b0 || cnt_cycle !== 32'd0 || dut.state_q !== RUN) begin
            $display("FAIL timeout_rst got halted=%b mem_err=%b cyc=%0d state=%0d exp 0/0/0/RUN", halted, mem_err, cnt_cycle, dut.state_q);
            errs++;
        end
    endtask

    task automatic test_halt_sat();
        do_reset();
        halt_req = 1'b1;
        dmem_req = 1'b1;
        #1;
        vecs++;
        if (ctl() !== 7'b0000001) begin
            $display("FAIL halt_ctl got=%b exp=%b", ctl(), 7'b0000001); errs++;
        end
        cyc();
        halt_req = 1'b0;
        dmem_req = 1'b0;
        br_taken_ex = 1'b1;
        #1;
        vecs++;
        if (halted !== 1'b1 || mem_err !== 1'b0 || dut.state_q !== HALT) begin
            $display("FAIL halt_state got halted=%b mem_err=%b state=%0d exp 1/0/HALT", halted, mem_err, dut.state_q); errs++;
        end
        vecs++;
        if (ctl() !== 7'b0000000) begin
            $display("FAIL halt_ignore_br got=%b exp=%b", ctl(), 7'b0000000); errs++;
        end
        cyc();
        vecs++;
        if (cnt_flush !== 32'd0 || cnt_stall !== 32'd0 || cnt_cycle !== 32'd1) begin
            $display("FAIL halt_cnt got flush=%0d stall=%0d cyc=%0d exp 0/0/1", cnt_flush, cnt_stall, cnt_cycle); errs++;
        end
        do_reset();
        stall_lu = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        stall_lu = 1'b0;
        vecs++;
        if (s_cnt_stall !== 3'd7 || s_cnt_cycle !== 3'd7) begin
            $display("FAIL sat_cnt got stall=%0d cyc=%0d exp 7/7", s_cnt_stall, s_cnt_cycle); errs++;
        end
        vecs++;
        if (cnt_stall !== 32'd10) begin
            $display("FAIL wide_stall got=%0d exp=10", cnt_stall); errs++;
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_halt_sat();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
